// File: rtl/inst_fetch_responder_if.sv
// inst_fetch_responder_if: fetch request/response bus plus a byte-wide loader for the instruction memory
interface inst_fetch_responder_if #(parameter int AW = 10);
    logic          fetch_req;
    logic [31:0]   pc_addr;
    logic [31:0]   instruction;
    logic          instr_valid;
    logic          busywait;
    logic          addr_err;
    logic [31:0]   fetch_count;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [7:0]    load_data;
    modport master (
        output fetch_req, pc_addr, load_en, load_addr, load_data,
        input  instruction, instr_valid, busywait, addr_err, fetch_count
    );
    modport slave (
        input  fetch_req, pc_addr, load_en, load_addr, load_data,
        output instruction, instr_valid, busywait, addr_err, fetch_count
    );
endinterface

// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: fixed-latency instruction memory responder with busywait, address checking and fetch counting
module inst_fetch_responder #(
    parameter int MEM_BYTES    = 1024,
    parameter int READ_LATENCY = 4
) (
    input logic                   CLK,
    input logic                   RESET,
    inst_fetch_responder_if.slave bus
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [7:0]    mem [0:MEM_BYTES-1];
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr_q;
    logic          bad_addr;
    logic [31:0]   word;

    assign bad_addr = (bus.pc_addr[1:0] != 2'b00) || (bus.pc_addr > 32'(MEM_BYTES - 4));
    assign word = {mem[addr_q + AW'(3)], mem[addr_q + AW'(2)], mem[addr_q + AW'(1)], mem[addr_q]};

    // memory contents survive RESET
    always_ff @(posedge CLK) begin
        if (bus.load_en) mem[bus.load_addr] <= bus.load_data;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state           <= IDLE;
            cnt             <= '0;
            addr_q          <= '0;
            bus.instruction <= '0;
            bus.instr_valid <= 1'b0;
            bus.busywait    <= 1'b0;
            bus.addr_err    <= 1'b0;
            bus.fetch_count <= '0;
        end else begin
            case (state)
                IDLE: if (bus.fetch_req) begin
                    addr_q <= bus.pc_addr[AW-1:0];
                    if (bad_addr) begin
                        state           <= RESP;
                        bus.instruction <= '0;
                        bus.instr_valid <= 1'b1;
                        bus.addr_err    <= 1'b1;
                    end else begin
                        state        <= WAIT;
                        bus.busywait <= 1'b1;
                        cnt          <= CW'(READ_LATENCY - 1);
                    end
                end
                WAIT: if (cnt == '0) begin
                    state           <= RESP;
                    bus.instruction <= word;
                    bus.instr_valid <= 1'b1;
                    bus.busywait    <= 1'b0;
                    bus.addr_err    <= 1'b0;
                    bus.fetch_count <= bus.fetch_count + 32'd1;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                default: begin
                    state           <= IDLE;
                    bus.instr_valid <= 1'b0;
                    bus.addr_err    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_responder.sv
// tb_inst_fetch_responder: directed checks of latency, error responses, reset abort and back-to-back fetches
module tb_inst_fetch_responder;
    localparam int MB = 1024;
    localparam int L  = 4;
    localparam int AW = 10;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int total = 0;
    int bad = 0;

    inst_fetch_responder_if #(.AW(AW)) bus ();
    inst_fetch_responder #(.MEM_BYTES(MB), .READ_LATENCY(L)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_word(input int a, input logic [31:0] d);
        for (int k = 0; k < 4; k++) begin
            bus.load_en   = 1'b1;
            bus.load_addr = AW'(a + k);
            bus.load_data = d[8*k +: 8];
            step();
        end
        bus.load_en = 1'b0;
    endtask

    // request pc for one edge, then move PC_ADDR away and drop FETCH_REQ while watching 12 cycles
    task automatic run_fetch(input logic [31:0] pc, output int valid_at, output int busy_n,
                             output int valid_n, output logic [31:0] instr, output logic err);
        valid_at = 0; busy_n = 0; valid_n = 0; instr = 32'hx; err = 1'bx;
        bus.fetch_req = 1'b1;
        bus.pc_addr   = pc;
        step();
        bus.fetch_req = 1'b0;
        bus.pc_addr   = pc ^ 32'hC;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            if (bus.busywait) busy_n++;
            if (bus.instr_valid) begin
                if (valid_n == 0) begin
                    valid_at = i;
                    instr = bus.instruction;
                    err = bus.addr_err;
                end
                valid_n++;
            end
        end
    endtask

    int va, bn, vn;
    logic [31:0] ins;
    logic er;
    int rise [3];
    logic [31:0] got_w [3];
    int nr, nv;
    logic busy_prev;

    initial begin
        bus.fetch_req = 1'b0;
        bus.pc_addr   = '0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        load_word(0, 32'h44332211);
        load_word(4, 32'hA5B6C7D8);
        load_word(8, 32'hDEADBEEF);
        step();
        step();
        @(negedge CLK);
        check("rst_instr", bus.instruction, 32'h0);
        check("rst_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_busy", 32'(bus.busywait), 32'h0);
        check("rst_err", 32'(bus.addr_err), 32'h0);
        check("rst_count", bus.fetch_count, 32'h0);
        RESET = 1'b0;
        step();

        run_fetch(32'h0, va, bn, vn, ins, er);
        check("basic_busy_cycles", 32'(bn), 32'd4);
        check("basic_valid_pulses", 32'(vn), 32'd1);
        check("basic_latency", 32'(va), 32'd5);
        check("basic_instr", ins, 32'h44332211);
        check("basic_err", 32'(er), 32'h0);
        check("basic_count", bus.fetch_count, 32'd1);

        run_fetch(32'h2, va, bn, vn, ins, er);
        check("mis_latency", 32'(va), 32'd1);
        check("mis_valid_pulses", 32'(vn), 32'd1);
        check("mis_err", 32'(er), 32'h1);
        check("mis_instr", ins, 32'h0);
        check("mis_busy_cycles", 32'(bn), 32'd0);
        check("mis_count", bus.fetch_count, 32'd1);

        run_fetch(32'(MB), va, bn, vn, ins, er);
        check("oor_latency", 32'(va), 32'd1);
        check("oor_err", 32'(er), 32'h1);
        check("oor_instr", ins, 32'h0);
        check("oor_busy_cycles", 32'(bn), 32'd0);
        check("oor_count", bus.fetch_count, 32'd1);

        run_fetch(32'(MB - 4), va, bn, vn, ins, er);
        check("last_word_err", 32'(er), 32'h0);
        check("last_word_count", bus.fetch_count, 32'd2);

        run_fetch(32'h4, va, bn, vn, ins, er);
        check("midflight_instr", ins, 32'hA5B6C7D8);
        check("midflight_latency", 32'(va), 32'd5);
        check("midflight_count", bus.fetch_count, 32'd3);

        bus.fetch_req = 1'b1;
        bus.pc_addr   = 32'h0;
        step();
        bus.fetch_req = 1'b0;
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        @(negedge CLK);
        check("abort_busy", 32'(bus.busywait), 32'h0);
        check("abort_valid", 32'(bus.instr_valid), 32'h0);
        check("abort_count", bus.fetch_count, 32'h0);
        check("abort_instr", bus.instruction, 32'h0);
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (bus.instr_valid) nv++;
        end
        check("abort_no_response", 32'(nv), 32'd0);
        run_fetch(32'h0, va, bn, vn, ins, er);
        check("post_abort_instr", ins, 32'h44332211);
        check("post_abort_count", bus.fetch_count, 32'd1);

        RESET = 1'b1;
        step();
        RESET = 1'b0;
        nr = 0; nv = 0; busy_prev = 1'b0;
        bus.fetch_req = 1'b1;
        bus.pc_addr   = 32'h0;
        for (int c = 0; c < 40 && nv < 3; c++) begin
            @(negedge CLK);
            if (bus.busywait && !busy_prev && nr < 3) begin
                rise[nr] = c;
                nr++;
            end
            busy_prev = bus.busywait;
            if (bus.instr_valid) begin
                got_w[nv] = bus.instruction;
                nv++;
                bus.pc_addr = bus.pc_addr + 32'd4;
                if (nv == 3) bus.fetch_req = 1'b0;
            end
        end
        bus.fetch_req = 1'b0;
        check("b2b_responses", 32'(nv), 32'd3);
        check("b2b_accepts", 32'(nr), 32'd3);
        if (nv == 3 && nr == 3) begin
            check("b2b_gap1", 32'(rise[1] - rise[0]), 32'd6);
            check("b2b_gap2", 32'(rise[2] - rise[1]), 32'd6);
            check("b2b_w0", got_w[0], 32'h44332211);
            check("b2b_w1", got_w[1], 32'hA5B6C7D8);
            check("b2b_w2", got_w[2], 32'hDEADBEEF);
        end
        step();
        check("b2b_count", bus.fetch_count, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
